centroid_accum_bank: RTL

Per-centroid accumulation stage for one k-means iteration. It consumes classified points from the distance/argmin stage: one point word plus its winning centroid index per transfer. It holds one coordinate-sum vector and one point count per centroid, and updates the selected entry through a single shared accumulator_adder instance. At end of pass it drains {sum, count} per centroid, in index order, to the downstream divider/centroid-update stage.

---
 rtl/kmeans_pkg.sv | 33 +++
 rtl/accumulator_adder.sv | 27 ++
 rtl/centroid_accum_bank.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_pkg
// Purpose  : Shared widths, the accumulation FSM state encoding and small
//            helpers for the k-means centroid accumulation stage.
// Revision : 1.0 - initial release
// ============================================================================
package kmeans_pkg;

  localparam int cordinate_width  = 13;
  localparam int accum_cord_width = 22;
  localparam int count_width      = 10;
  localparam int centroid_num     = 8;
  localparam int idx_width        = 3;
  localparam int num_coords       = 7;
  localparam int accum_width      = num_coords * accum_cord_width;  // 154
  localparam int dataWidth        = num_coords * cordinate_width;   // 91

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // An index names a real bank entry only below centroid_num; the index
  // field may be wider than the bank when centroid_num is not a power of two.
  function automatic logic idx_in_range(input logic [idx_width-1:0] idx);
    return (int'(idx) < centroid_num);
  endfunction

endpackage : kmeans_pkg
`default_nettype wire

// File: rtl/accumulator_adder.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_adder
// Purpose  : Adds one point word into one coordinate-sum vector. Each point
//            coordinate is zero-extended and added to its lane; lanes wrap
//            independently with no carry between them.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_adder
  import kmeans_pkg::*;
(
  input  logic [dataWidth-1:0]   point,
  input  logic [accum_width-1:0] sum_in,
  output logic [accum_width-1:0] sum_out
);

  localparam int EXT_W = accum_cord_width - cordinate_width;

  // One independent lane adder per coordinate.
  for (genvar c = 0; c < num_coords; c++) begin : g_coord
    assign sum_out[c*accum_cord_width +: accum_cord_width] =
        sum_in[c*accum_cord_width +: accum_cord_width] +
        {{EXT_W{1'b0}}, point[c*cordinate_width +: cordinate_width]};
  end

endmodule : accumulator_adder
`default_nettype wire

// File: rtl/centroid_accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : centroid_accum_bank
// Purpose  : Per-centroid coordinate-sum and point-count bank for one k-means
//            pass. Classified points are folded into the selected entry via a
//            single shared adder; at end of pass every entry is drained in
//            index order as {sum, count}.
// Revision : 1.0 - initial release
// ============================================================================
module centroid_accum_bank
  import kmeans_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   point_valid,
  output logic                   point_ready,
  input  logic [dataWidth-1:0]   point,
  input  logic [idx_width-1:0]   centroid_idx,
  input  logic                   last_point,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [idx_width-1:0]   out_idx,
  output logic [accum_width-1:0] out_accum,
  output logic [count_width-1:0] out_count,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow
);

  state_t                 state;
  logic [idx_width-1:0]   drain_ptr;

  logic [accum_width-1:0] sums   [centroid_num];
  logic [count_width-1:0] counts [centroid_num];

  logic                   xfer;
  logic                   idx_ok;
  logic                   cnt_sat;
  logic [accum_width-1:0] sel_sum;
  logic [count_width-1:0] sel_count;
  logic [accum_width-1:0] new_sum;
  logic [accum_width-1:0] drain_sum;
  logic [count_width-1:0] drain_count;

  // point_ready is high exactly in ACCUM, so this is the accepted-point strobe.
  assign xfer    = point_valid && point_ready;
  assign idx_ok  = idx_in_range(centroid_idx);
  assign cnt_sat = (sel_count == {count_width{1'b1}});

  // Read-side mux of the entry addressed by the incoming point; reads the
  // registered bank so back-to-back hits on one entry see the prior update.
  always_comb begin
    sel_sum   = '0;
    sel_count = '0;
    for (int i = 0; i < centroid_num; i++) begin
      if (int'(centroid_idx) == i) begin
        sel_sum   = sums[i];
        sel_count = counts[i];
      end
    end
  end

  accumulator_adder u_adder (
    .point   (point),
    .sum_in  (sel_sum),
    .sum_out (new_sum)
  );

  // Drain-side mux of the entry addressed by the drain pointer.
  always_comb begin
    drain_sum   = '0;
    drain_count = '0;
    for (int i = 0; i < centroid_num; i++) begin
      if (int'(drain_ptr) == i) begin
        drain_sum   = sums[i];
        drain_count = counts[i];
      end
    end
  end

  assign out_idx   = drain_ptr;
  assign out_accum = out_valid ? drain_sum   : '0;
  assign out_count = out_valid ? drain_count : '0;

  // Bank storage and sticky overflow: cleared on reset and at pass start,
  // updated on each accepted point unless the index is bad or count is full.
  always_ff @(posedge clk) begin
    if (rst || (state == ST_CLEAR)) begin
      for (int i = 0; i < centroid_num; i++) begin
        sums[i]   <= '0;
        counts[i] <= '0;
      end
      overflow <= 1'b0;
    end else if (xfer) begin
      if (!idx_ok || cnt_sat) begin
        overflow <= 1'b1;
      end else begin
        for (int i = 0; i < centroid_num; i++) begin
          if (int'(centroid_idx) == i) begin
            sums[i]   <= new_sum;
            counts[i] <= sel_count + 1'b1;
          end
        end
      end
    end
  end

  // Pass sequencing FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      drain_ptr   <= '0;
      point_ready <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state       <= ST_ACCUM;
          point_ready <= 1'b1;
        end
        ST_ACCUM: begin
          if (xfer && last_point) begin
            state       <= ST_DRAIN;
            point_ready <= 1'b0;
            out_valid   <= 1'b1;
            drain_ptr   <= '0;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (int'(drain_ptr) == centroid_num - 1) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              drain_ptr <= '0;
            end else begin
              drain_ptr <= drain_ptr + 1'b1;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          point_ready <= 1'b0;
          out_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule : centroid_accum_bank
`default_nettype wire
